// File: rtl/add_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_pkg
//  Purpose  : Shared types for the add/subtract arbiter slice: operation
//             encoding carried on req_op, and the arbiter FSM state encoding.
//  Contents : op_t    - 2-bit operation code (add, sub, clear, load)
//             state_t - 2-bit FSM state (IDLE, EXEC, RESP)
//  Revision : 1.0 - initial release
// ============================================================================
package add_sub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CLR = 2'b10,
    OP_LD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage : add_sub_pkg
`default_nettype wire

// File: rtl/add_sub_alu.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_alu
//  Purpose  : Combinational add/subtract/clear/load step applied to the shared
//             accumulator value S with operand A.
//  Ports    : s     in  N  current accumulator value
//             a     in  N  operand
//             op    in  2  operation (op_t)
//             r     out N  new accumulator value
//             carry out 1  add: carry-out, sub: borrow (S < A unsigned)
//             ovf   out 1  signed overflow of this operation
//  Options  : ADD_SUB_ARB_SAT_EN - when defined, an overflowing add/sub
//             saturates r to the signed limit instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module add_sub_alu
  import add_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] s,
  input  logic [N-1:0] a,
  input  op_t          op,
  output logic [N-1:0] r,
  output logic         carry,
  output logic         ovf
);

  // Both paths are N+1 bits wide; the extra bit is carry-out for the add
  // and borrow for the subtract (it goes high exactly when S < A).
  logic [N:0]   w_sum;
  logic [N:0]   w_diff;
  logic [N-1:0] w_res;
  logic         w_ovf;

  assign w_sum  = {1'b0, s} + {1'b0, a};
  assign w_diff = {1'b0, s} - {1'b0, a};

  always_comb begin
    w_res = '0;
    carry = 1'b0;
    w_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_sum[N-1:0];
        carry = w_sum[N];
        w_ovf = (s[N-1] == a[N-1]) && (w_sum[N-1] != s[N-1]);
      end
      OP_SUB: begin
        w_res = w_diff[N-1:0];
        carry = w_diff[N];
        w_ovf = (s[N-1] != a[N-1]) && (w_diff[N-1] != s[N-1]);
      end
      OP_CLR: begin
        w_res = '0;
      end
      default: begin
        w_res = a;
      end
    endcase
  end

  assign ovf = w_ovf;

`ifdef ADD_SUB_ARB_SAT_EN
  // An add/sub can only overflow away from the sign of S, so the sign of S
  // picks the limit: non-negative S overflows positive, negative S negative.
  assign r = w_ovf ? (s[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                   : w_res;
`else
  assign r = w_res;
`endif

endmodule : add_sub_alu
`default_nettype wire

// File: rtl/add_sub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_arbiter
//  Purpose  : Round-robin arbiter sharing one N-bit add/subtract accumulator
//             between NREQ requesters; returns the new accumulator value,
//             carry/borrow and signed overflow tagged with the requester ID.
//  Ports    : clk       in  1       system clock, rising edge
//             aclr      in  1       asynchronous active-low reset
//             req_valid in  NREQ    per-requester request valid
//             req_ready out NREQ    per-requester accept, one-hot or zero
//             req_op    in  2*NREQ  per-requester op (00 add,01 sub,10 clr,11 ld)
//             req_data  in  N*NREQ  per-requester operand
//             rsp_valid out 1       response valid
//             rsp_ready in  1       response consumer ready
//             rsp_id    out IDW     index of the served requester
//             rsp_sum   out N       accumulator value after the op
//             rsp_carry out 1       carry-out (add) / borrow (sub)
//             rsp_ovf   out 1       signed overflow of the op
//  Options  : ADD_SUB_ARB_SAT_EN - saturating add/sub (inside add_sub_alu).
//  Revision : 1.0 - initial release
// ============================================================================
module add_sub_arbiter
  import add_sub_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [N*NREQ-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_carry,
  output logic              rsp_ovf
);

  state_t         r_state;
  logic [N-1:0]   r_acc;
  logic [IDW-1:0] r_ptr;
  op_t            r_op;
  logic [N-1:0]   r_a;
  logic [IDW-1:0] r_id;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [N-1:0]   r_rsp_sum;
  logic           r_rsp_carry;
  logic           r_rsp_ovf;

  logic [N-1:0]   w_data [NREQ];
  op_t            w_op   [NREQ];
  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic [IDW:0]   w_cand;
  logic [IDW-1:0] w_ptr_next;
  logic [N-1:0]   w_r;
  logic           w_carry;
  logic           w_ovf;

  // Unpack the flat request buses into per-requester views.
  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign w_data[g] = req_data[g*N +: N];
    assign w_op[g]   = op_t'(req_op[2*g +: 2]);
  end

  // Round-robin search: start at the pointer, walk upward, wrap at NREQ-1.
  // The candidate is kept one bit wider so the wrap works for any NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_cand >= (IDW+1)'(NREQ)) begin
        w_cand = w_cand - (IDW+1)'(NREQ);
      end
      if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == ST_IDLE && w_found) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  assign w_ptr_next = (r_rsp_id == IDW'(NREQ-1)) ? '0 : r_rsp_id + IDW'(1);

  add_sub_alu #(
    .N (N)
  ) u_alu (
    .s     (r_acc),
    .a     (r_a),
    .op    (r_op),
    .r     (w_r),
    .carry (w_carry),
    .ovf   (w_ovf)
  );

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_ptr       <= '0;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_op    <= w_op[w_winner];
            r_a     <= w_data[w_winner];
            r_id    <= w_winner;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_acc       <= w_r;
          r_rsp_sum   <= w_r;
          r_rsp_carry <= w_carry;
          r_rsp_ovf   <= w_ovf;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_carry = r_rsp_carry;
  assign rsp_ovf   = r_rsp_ovf;

endmodule : add_sub_arbiter
`default_nettype wire

// File: tb/tb_add_sub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sub_arbiter
//  Purpose  : Self-checking bench for add_sub_arbiter (N=8, NREQ=4): directed
//             scenarios followed by randomized traffic against an integer
//             reference model of the accumulator and round-robin pointer.
//  Options  : ADD_SUB_ARB_SAT_EN - expected values follow the saturating mode.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add_sub_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              aclr;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [N*NREQ-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_carry;
  logic              rsp_ovf;

  int checks = 0;
  int errors = 0;

  // Stimulus state and reference model state.
  logic [3:0] vld;
  logic [1:0] op_q   [NREQ];
  logic [7:0] data_q [NREQ];
  int         s_m;
  int         ptr_m;

  add_sub_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the 8-bit accumulator.
  function automatic void ref_op(input int op, input int a, input int s,
                                 output int r, output int c, output int v);
    int ss, sa, sr;
    ss = (s >= 128) ? s - 256 : s;
    sa = (a >= 128) ? a - 256 : a;
    r = 0; c = 0; v = 0; sr = 0;
    case (op)
      0: begin r = (s + a) % 256;       c = int'((s + a) > 255); sr = ss + sa; end
      1: begin r = (s - a + 256) % 256; c = int'(s < a);         sr = ss - sa; end
      2: begin r = 0; end
      default: begin r = a; end
    endcase
    if (op < 2) v = int'(sr > 127 || sr < -128);
`ifdef ADD_SUB_ARB_SAT_EN
    if (v != 0) r = (sr > 127) ? 127 : 128;
`endif
  endfunction

  task automatic drive();
    req_valid = vld;
    for (int k = 0; k < NREQ; k++) begin
      req_op[2*k +: 2]   = op_q[k];
      req_data[8*k +: 8] = data_q[k];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    aclr = 1'b0;
    vld = '0;
    drive();
    @(negedge clk);
    aclr = 1'b1;
    s_m = 0;
    ptr_m = 0;
    #1;
  endtask

  // One full transaction from grant to response handshake, checked against
  // the model. hold = cycles rsp_ready stays low in RESP; drop = requester
  // withdraws after being accepted (otherwise it issues a fresh random op).
  task automatic serve(input int hold, input bit drop,
                       output int id, output int sum, output int cy, output int ov);
    int w, er, ec, ev, waited;
    drive();
    rsp_ready = (hold == 0);
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && vld[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
    end
    if (w < 0) w = 0;
    waited = 0;
    while (req_ready == '0 && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("grant", req_ready, 32'(1) << w);
    ref_op(int'(op_q[w]), int'(data_q[w]), s_m, er, ec, ev);
    s_m = er;
    @(posedge clk); @(negedge clk);
    if (drop) vld[w] = 1'b0;
    else begin
      op_q[w]   = 2'($urandom_range(0, 3));
      data_q[w] = 8'($urandom_range(0, 255));
    end
    drive();
    #1;
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_req_ready", req_ready, 0);
    @(posedge clk); @(negedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, w);
    chk("rsp_sum", rsp_sum, er);
    chk("rsp_carry", rsp_carry, ec);
    chk("rsp_ovf", rsp_ovf, ev);
    chk("resp_req_ready", req_ready, 0);
    id = int'(rsp_id); sum = int'(rsp_sum); cy = int'(rsp_carry); ov = int'(rsp_ovf);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_sum", rsp_sum, er);
      chk("hold_id", rsp_id, w);
      chk("hold_flags", {rsp_carry, rsp_ovf}, {ec[0], ev[0]});
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("post_rsp_valid", rsp_valid, 0);
    ptr_m = (w + 1) % NREQ;
  endtask

  task automatic set_req(input int k, input int op, input int d);
    op_q[k]   = 2'(op);
    data_q[k] = 8'(d);
    vld[k]    = 1'b1;
  endtask

  initial begin : main
    int id, sum, cy, ov;
    aclr = 1'b0;
    rsp_ready = 1'b0;
    vld = '0;
    for (int k = 0; k < NREQ; k++) begin op_q[k] = '0; data_q[k] = '0; end
    drive();
    s_m = 0; ptr_m = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_sum", rsp_sum, 0);
    chk("reset_flags", {rsp_carry, rsp_ovf}, 0);
    chk("reset_req_ready", req_ready, 0);
    aclr = 1'b1;
    @(negedge clk);

    // Load then add on requester 1.
    set_req(1, 3, 8'h10); serve(0, 1, id, sum, cy, ov);
    chk("t1_load_sum", sum, 8'h10); chk("t1_load_id", id, 1);
    set_req(1, 0, 8'h05); serve(0, 1, id, sum, cy, ov);
    chk("t1_add_sum", sum, 8'h15); chk("t1_add_flags", {cy[0], ov[0]}, 0);

    // Positive overflow on add.
    set_req(1, 3, 8'h7F); serve(0, 1, id, sum, cy, ov);
    set_req(1, 0, 8'h01); serve(0, 1, id, sum, cy, ov);
`ifdef ADD_SUB_ARB_SAT_EN
    chk("t3_sum", sum, 8'h7F);
`else
    chk("t3_sum", sum, 8'h80);
`endif
    chk("t3_ovf", ov, 1); chk("t3_carry", cy, 0);

    // Borrow without overflow, then negative overflow on subtract.
    set_req(2, 2, 8'h00); serve(0, 1, id, sum, cy, ov);
    set_req(2, 1, 8'h01); serve(0, 1, id, sum, cy, ov);
    chk("t4a_sum", sum, 8'hFF); chk("t4a_carry", cy, 1); chk("t4a_ovf", ov, 0);
    set_req(2, 3, 8'h80); serve(0, 1, id, sum, cy, ov);
    set_req(2, 1, 8'h01); serve(0, 1, id, sum, cy, ov);
`ifdef ADD_SUB_ARB_SAT_EN
    chk("t4b_sum", sum, 8'h80);
`else
    chk("t4b_sum", sum, 8'h7F);
`endif
    chk("t4b_ovf", ov, 1); chk("t4b_carry", cy, 0);

    // Back-pressure: response held 5 cycles while another requester waits.
    set_req(0, 0, 8'h11); set_req(3, 0, 8'h22);
    serve(5, 1, id, sum, cy, ov);
    serve(0, 1, id, sum, cy, ov);

    // All requesters held valid with rsp_ready high: 0,1,2,3,0 from reset.
    do_reset();
    for (int k = 0; k < NREQ; k++) set_req(k, $urandom_range(0, 3), $urandom_range(0, 255));
    for (int n = 0; n < 5; n++) begin
      serve(0, 0, id, sum, cy, ov);
      chk("t2_order", id, n % NREQ);
    end

    // Reset pulse during EXEC aborts the op; pointer returns to 0.
    vld = '0;
    set_req(2, 3, 8'h5A);
    drive();
    rsp_ready = 1'b1;
    #1;
    chk("t6_grant", req_ready, 4'b0100);
    @(posedge clk); @(negedge clk);
    vld = '0; drive();
    aclr = 1'b0;
    #1;
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rsp_sum", rsp_sum, 0);
    chk("t6_req_ready", req_ready, 0);
    @(negedge clk);
    aclr = 1'b1;
    s_m = 0; ptr_m = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("t6_no_rsp", rsp_valid, 0);
    end
    for (int k = 0; k < NREQ; k++) set_req(k, 0, 8'h05);
    serve(0, 1, id, sum, cy, ov);
    chk("t6_first_id", id, 0);
    chk("t6_sum_from_zero", sum, 8'h05);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      vld = 4'($urandom_range(1, 15));
      for (int k = 0; k < NREQ; k++) begin
        op_q[k]   = 2'($urandom_range(0, 3));
        data_q[k] = 8'($urandom_range(0, 255));
      end
      serve($urandom_range(0, 2), 1'($urandom_range(0, 1)), id, sum, cy, ov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_add_sub_arbiter
`default_nettype wire
